i2c_reg_sequencer: RTL and testbench

I2C_REG_SEQUENCER -- requirements
Module: i2c_reg_sequencer

---
 rtl/i2c_reg_sequencer.sv | 263 ++++++++++++++++++++++++++
 tb/tb_i2c_reg_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_sequencer.sv
// ---------------------------------------------------------------------------
// i2c_reg_sequencer
//
// Sequences single-byte I2C register accesses on top of an I2C byte
// controller. A write runs the phases ADDR_W -> REG -> DATA. A read runs
// ADDR_W -> REG -> RESTART -> ADDR_R -> READ. A NAK never aborts the
// sequence; it is accumulated into error_o and reported with done_o.
//
// Optional feature (macro I2C_SEQ_TIMEOUT_EN):
//   When defined, a 16-bit per-phase watchdog counts cycles spent waiting on
//   the controller. Reaching TIMEOUT_CYCLES sets error_o and finishes the
//   transaction without updating rdata_o. When undefined, there is no
//   watchdog and the waits are unbounded.
//
// Ports
//   clk_i             master clock, rising edge
//   rst_ni            asynchronous active-low reset
//   start_i           one-cycle transaction request, honoured only when idle
//   dev_address_i     7-bit slave address      (latched on accepted start)
//   reg_address_i     8-bit register index     (latched on accepted start)
//   rw_i              0 = register write, 1 = register read (latched)
//   wdata_i           byte to write            (latched)
//   rdata_o           byte read, valid from done_o until the next start
//   done_o            one-cycle pulse at transaction end
//   error_o           sticky NAK/timeout flag, valid with done_o
//   busy_o            high from the cycle after accepted start until done_o
//   ctl_trigger_o     one-cycle byte request to the controller
//   ctl_restart_o     one-cycle repeated-start request to the controller
//   ctl_last_byte_o   high during the DATA and READ phases
//   ctl_read_write_o  bus direction bit for the address phase
//   ctl_address_o     slave address for the controller
//   ctl_write_data_o  byte to transmit in the current phase
//   ctl_read_data_i   byte received by the controller
//   ctl_ack_error_i   NAK indication, sampled when ctl_busy_i falls
//   ctl_busy_i        controller busy
// ---------------------------------------------------------------------------
module i2c_reg_sequencer #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'hFFFF
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic [6:0] dev_address_i,
    input  logic [7:0] reg_address_i,
    input  logic       rw_i,
    input  logic [7:0] wdata_i,
    output logic [7:0] rdata_o,
    output logic       done_o,
    output logic       error_o,
    output logic       busy_o,
    output logic       ctl_trigger_o,
    output logic       ctl_restart_o,
    output logic       ctl_last_byte_o,
    output logic       ctl_read_write_o,
    output logic [6:0] ctl_address_o,
    output logic [7:0] ctl_write_data_o,
    input  logic [7:0] ctl_read_data_i,
    input  logic       ctl_ack_error_i,
    input  logic       ctl_busy_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT_HI,
        S_WAIT_LO,
        S_RESTART,
        S_FINISH
    } state_e;

    typedef enum logic [2:0] {
        PH_ADDR_W,
        PH_REG,
        PH_DATA,
        PH_RESTART,
        PH_ADDR_R,
        PH_READ
    } phase_e;

    state_e      state_q;
    phase_e      phase_q;
    phase_e      phase_d;
    logic [7:0]  wbyte_d;
    logic        last_d;

    logic [6:0]  dev_q;
    logic [7:0]  reg_q;
    logic        rw_q;
    logic [7:0]  wdata_q;

    logic [7:0]  rdata_q;
    logic        done_q;
    logic        error_q;
    logic        busy_q;
    logic        ctl_trigger_q;
    logic        ctl_restart_q;
    logic        ctl_last_byte_q;
    logic        ctl_read_write_q;
    logic [6:0]  ctl_address_q;
    logic [7:0]  ctl_write_data_q;

    logic        timeout_hit;

`ifdef I2C_SEQ_TIMEOUT_EN
    logic [15:0] wdog_q;

    // wdog_q holds the number of completed wait cycles in this phase, so the
    // limit is reached on the TIMEOUT_CYCLES-th wait cycle.
    assign timeout_hit = (wdog_q == (TIMEOUT_CYCLES - 16'd1));
`else
    logic        unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
`endif

    // Phase that follows the current one, and the controller settings it needs.
    always_comb begin
        phase_d = PH_ADDR_W;
        case (phase_q)
            PH_ADDR_W:  phase_d = PH_REG;
            PH_REG:     phase_d = rw_q ? PH_RESTART : PH_DATA;
            PH_RESTART: phase_d = PH_ADDR_R;
            PH_ADDR_R:  phase_d = PH_READ;
            default:    phase_d = PH_ADDR_W;
        endcase

        wbyte_d = '0;
        case (phase_d)
            PH_ADDR_W: wbyte_d = {dev_q, 1'b0};
            PH_REG:    wbyte_d = reg_q;
            PH_DATA:   wbyte_d = wdata_q;
            PH_ADDR_R: wbyte_d = {dev_q, 1'b1};
            default:   wbyte_d = '0;
        endcase

        last_d = (phase_d == PH_DATA) || (phase_d == PH_READ);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q          <= S_IDLE;
            phase_q          <= PH_ADDR_W;
            dev_q            <= '0;
            reg_q            <= '0;
            rw_q             <= 1'b0;
            wdata_q          <= '0;
            rdata_q          <= '0;
            done_q           <= 1'b0;
            error_q          <= 1'b0;
            busy_q           <= 1'b0;
            ctl_trigger_q    <= 1'b0;
            ctl_restart_q    <= 1'b0;
            ctl_last_byte_q  <= 1'b0;
            ctl_read_write_q <= 1'b0;
            ctl_address_q    <= '0;
            ctl_write_data_q <= '0;
`ifdef I2C_SEQ_TIMEOUT_EN
            wdog_q           <= '0;
`endif
        end else begin
            // Single-cycle strobes default low.
            ctl_trigger_q <= 1'b0;
            ctl_restart_q <= 1'b0;
            done_q        <= 1'b0;

            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        dev_q            <= dev_address_i;
                        reg_q            <= reg_address_i;
                        rw_q             <= rw_i;
                        wdata_q          <= wdata_i;
                        busy_q           <= 1'b1;
                        error_q          <= 1'b0;
                        phase_q          <= PH_ADDR_W;
                        ctl_address_q    <= dev_address_i;
                        ctl_write_data_q <= {dev_address_i, 1'b0};
                        ctl_read_write_q <= 1'b0;
                        ctl_last_byte_q  <= 1'b0;
                        ctl_trigger_q    <= 1'b1;
                        state_q          <= S_TRIG;
                    end
                end

                S_TRIG: begin
`ifdef I2C_SEQ_TIMEOUT_EN
                    wdog_q  <= '0;
`endif
                    state_q <= S_WAIT_HI;
                end

                S_WAIT_HI, S_WAIT_LO: begin
`ifdef I2C_SEQ_TIMEOUT_EN
                    wdog_q <= wdog_q + 16'd1;
`endif
                    if (timeout_hit) begin
                        error_q          <= 1'b1;
                        done_q           <= 1'b1;
                        busy_q           <= 1'b0;
                        ctl_last_byte_q  <= 1'b0;
                        ctl_read_write_q <= 1'b0;
                        state_q          <= S_FINISH;
                    end else if (state_q == S_WAIT_HI) begin
                        if (ctl_busy_i) begin
                            state_q <= S_WAIT_LO;
                        end
                    end else if (!ctl_busy_i) begin
                        error_q <= error_q | ctl_ack_error_i;
                        if ((phase_q == PH_DATA) || (phase_q == PH_READ)) begin
                            // rdata/done are registered together so rdata is
                            // already valid in the done cycle.
                            if (phase_q == PH_READ) begin
                                rdata_q <= ctl_read_data_i;
                            end
                            done_q           <= 1'b1;
                            busy_q           <= 1'b0;
                            ctl_last_byte_q  <= 1'b0;
                            ctl_read_write_q <= 1'b0;
                            state_q          <= S_FINISH;
                        end else if (phase_d == PH_RESTART) begin
                            phase_q          <= PH_RESTART;
                            ctl_restart_q    <= 1'b1;
                            ctl_read_write_q <= 1'b1;
                            state_q          <= S_RESTART;
                        end else begin
                            phase_q          <= phase_d;
                            ctl_write_data_q <= wbyte_d;
                            ctl_last_byte_q  <= last_d;
                            ctl_trigger_q    <= 1'b1;
                            state_q          <= S_TRIG;
                        end
                    end
                end

                S_RESTART: begin
                    phase_q          <= phase_d;
                    ctl_write_data_q <= wbyte_d;
                    ctl_last_byte_q  <= last_d;
                    ctl_trigger_q    <= 1'b1;
                    state_q          <= S_TRIG;
                end

                S_FINISH: begin
                    phase_q <= PH_ADDR_W;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign rdata_o          = rdata_q;
    assign done_o           = done_q;
    assign error_o          = error_q;
    assign busy_o           = busy_q;
    assign ctl_trigger_o    = ctl_trigger_q;
    assign ctl_restart_o    = ctl_restart_q;
    assign ctl_last_byte_o  = ctl_last_byte_q;
    assign ctl_read_write_o = ctl_read_write_q;
    assign ctl_address_o    = ctl_address_q;
    assign ctl_write_data_o = ctl_write_data_q;

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// ---------------------------------------------------------------------------
// tb_i2c_reg_sequencer
//
// Directed + randomized bench for i2c_reg_sequencer. A behavioural byte
// controller answers each trigger after a random delay, with a planned NAK
// pattern and random read data, and logs every trigger/restart it sees.
// Expected results come from the register-access rules: the phase list of a
// write or read, the OR of the planned NAKs, and the byte returned on the
// final read phase.
// ---------------------------------------------------------------------------
module tb_i2c_reg_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [6:0] dev_address = '0;
    logic [7:0] reg_address = '0;
    logic       rw = 1'b0;
    logic [7:0] wdata = '0;
    logic [7:0] rdata;
    logic       done;
    logic       error;
    logic       busy;
    logic       ctl_trigger;
    logic       ctl_restart;
    logic       ctl_last_byte;
    logic       ctl_read_write;
    logic [6:0] ctl_address;
    logic [7:0] ctl_write_data;
    logic [7:0] ctl_read_data = '0;
    logic       ctl_ack_error = 1'b0;
    logic       ctl_busy = 1'b0;

    always #5 clk = ~clk;

    i2c_reg_sequencer #(.TIMEOUT_CYCLES(16'd100)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .start_i          (start),
        .dev_address_i    (dev_address),
        .reg_address_i    (reg_address),
        .rw_i             (rw),
        .wdata_i          (wdata),
        .rdata_o          (rdata),
        .done_o           (done),
        .error_o          (error),
        .busy_o           (busy),
        .ctl_trigger_o    (ctl_trigger),
        .ctl_restart_o    (ctl_restart),
        .ctl_last_byte_o  (ctl_last_byte),
        .ctl_read_write_o (ctl_read_write),
        .ctl_address_o    (ctl_address),
        .ctl_write_data_o (ctl_write_data),
        .ctl_read_data_i  (ctl_read_data),
        .ctl_ack_error_i  (ctl_ack_error),
        .ctl_busy_i       (ctl_busy)
    );

    typedef struct packed {
        logic [7:0] wd;
        logic       lb;
        logic       rw;
        logic [6:0] ad;
    } trig_t;

    int          total = 0;
    int          bad = 0;

    trig_t       trigs[$];
    int          restart_at[$];
    logic        restart_rw[$];
    logic [7:0]  given_rd[0:1023];

    int          stuck_at = -1;
    int          txn_base = 0;
    logic [4:0]  nak_mask = '0;
    logic        force_rd_en = 1'b0;
    logic [7:0]  force_rd = '0;
    logic [7:0]  exp_rdata = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Behavioural byte controller: logs strobes and answers each trigger.
    initial begin
        int st;
        int dly;
        int hold;
        int my;
        int k;
        st = 0; dly = 0; hold = 0; my = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                st = 0;
                ctl_busy = 1'b0;
                ctl_ack_error = 1'b0;
            end else begin
                if (ctl_restart) begin
                    restart_at.push_back(trigs.size());
                    restart_rw.push_back(ctl_read_write);
                end
                case (st)
                    0: if (ctl_trigger) begin
                        my = trigs.size();
                        trigs.push_back({ctl_write_data, ctl_last_byte, ctl_read_write, ctl_address});
                        dly = $urandom_range(0, 2);
                        st = 1;
                    end
                    1: if (dly == 0) begin
                        ctl_busy = 1'b1;
                        ctl_ack_error = 1'($urandom_range(0, 1));
                        ctl_read_data = 8'($urandom);
                        hold = $urandom_range(1, 4);
                        st = 2;
                    end else begin
                        dly--;
                    end
                    default: if (my != stuck_at) begin
                        if (hold == 0) begin
                            k = my - txn_base;
                            ctl_busy = 1'b0;
                            ctl_ack_error = (k >= 0 && k < 5) ? nak_mask[k] : 1'b0;
                            ctl_read_data = force_rd_en ? force_rd : 8'($urandom);
                            if (my < 1024) given_rd[my] = ctl_read_data;
                            st = 0;
                        end else begin
                            hold--;
                        end
                    end
                endcase
            end
        end
    end

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_busy"}, 32'(busy), 0);
        chk({pfx, "_done"}, 32'(done), 0);
        chk({pfx, "_error"}, 32'(error), 0);
        chk({pfx, "_rdata"}, 32'(rdata), 0);
        chk({pfx, "_trigger"}, 32'(ctl_trigger), 0);
        chk({pfx, "_restart"}, 32'(ctl_restart), 0);
        chk({pfx, "_last_byte"}, 32'(ctl_last_byte), 0);
        chk({pfx, "_read_write"}, 32'(ctl_read_write), 0);
        chk({pfx, "_address"}, 32'(ctl_address), 0);
        chk({pfx, "_write_data"}, 32'(ctl_write_data), 0);
    endtask

    // One register access; mode 1 also pulses start while busy and on done.
    task automatic do_txn(input logic t_rw, input logic [6:0] t_dev, input logic [7:0] t_reg,
                          input logic [7:0] t_wd, input logic [4:0] t_mask, input int mode);
        int   base;
        int   rbase;
        int   n;
        logic got;
        logic exp_err;
        trig_t tr;
        base = trigs.size();
        rbase = restart_at.size();
        n = t_rw ? 4 : 3;
        exp_err = |(t_mask & (t_rw ? 5'h0F : 5'h07));
        txn_base = base;
        nak_mask = t_mask;

        @(negedge clk);
        rw = t_rw; dev_address = t_dev; reg_address = t_reg; wdata = t_wd; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rw = 1'($urandom); dev_address = 7'($urandom); reg_address = 8'($urandom); wdata = 8'($urandom);
        chk("busy_after_start", 32'(busy), 1);

        got = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (done === 1'b1) begin
                got = 1'b1;
                break;
            end
            start = (mode == 1) && (c == 3);
            @(negedge clk);
        end
        chk("done_seen", 32'(got), 1);
        chk("error_at_done", 32'(error), 32'(exp_err));
        if (t_rw) exp_rdata = given_rd[(base + 3) % 1024];
        chk("rdata_at_done", 32'(rdata), 32'(exp_rdata));
        chk("busy_at_done", 32'(busy), 0);
        if (mode == 1) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("done_one_cycle", 32'(done), 0);
        repeat (3) @(negedge clk);
        chk("busy_after_done", 32'(busy), 0);
        chk("trigger_count", 32'(trigs.size() - base), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (base + i < trigs.size()) begin
                tr = trigs[base + i];
                chk($sformatf("trig%0d_address", i), 32'(tr.ad), 32'(t_dev));
                chk($sformatf("trig%0d_read_write", i), 32'(tr.rw), 32'(t_rw && i >= 2));
                chk($sformatf("trig%0d_last_byte", i), 32'(tr.lb), 32'(i == n - 1));
                if (i == 1) chk("trig1_reg_byte", 32'(tr.wd), 32'(t_reg));
                if (!t_rw && i == 2) chk("trig2_data_byte", 32'(tr.wd), 32'(t_wd));
            end
        end
        chk("restart_count", 32'(restart_at.size() - rbase), 32'(t_rw));
        if (t_rw && restart_at.size() > rbase) begin
            chk("restart_before_third", 32'(restart_at[rbase]), 32'(base + 2));
            chk("restart_read_write", 32'(restart_rw[rbase]), 1);
        end
    endtask

    initial begin
        logic [4:0] m;
        int   base;
        logic got;
        int   cnt;

        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Basic write and read with fixed values.
        do_txn(1'b0, 7'h50, 8'h10, 8'hA5, 5'b00000, 0);
        force_rd_en = 1'b1; force_rd = 8'h3C;
        do_txn(1'b1, 7'h50, 8'h02, 8'h00, 5'b00000, 0);
        chk("read_value_3c", 32'(rdata), 32'h3C);
        force_rd_en = 1'b0;

        // NAK on the address phase keeps going; next clean access clears error.
        do_txn(1'b0, 7'h50, 8'h10, 8'h5A, 5'b00001, 0);
        do_txn(1'b0, 7'h21, 8'h33, 8'h44, 5'b00000, 0);

        // Start while busy and on the done cycle.
        do_txn(1'b0, 7'h12, 8'h34, 8'h56, 5'b00000, 1);
        do_txn(1'b1, 7'h7F, 8'hFF, 8'h00, 5'b01000, 1);

        // Randomized accesses.
        for (int t = 0; t < 24; t++) begin
            m = '0;
            for (int b = 0; b < 5; b++) if ($urandom_range(0, 4) == 0) m[b] = 1'b1;
            do_txn(1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom), m, $urandom_range(0, 1));
        end

`ifdef I2C_SEQ_TIMEOUT_EN
        // Controller stuck busy on the first phase: watchdog ends the access.
        stuck_at = trigs.size();
        txn_base = trigs.size();
        nak_mask = '0;
        @(negedge clk);
        rw = 1'b1; dev_address = 7'h50; reg_address = 8'h02; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("timeout_trigger", 32'(ctl_trigger), 1);
        got = 1'b0;
        cnt = 0;
        for (int c = 1; c < 400; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                got = 1'b1;
                cnt = c;
                break;
            end
        end
        chk("timeout_done_seen", 32'(got), 1);
        chk("timeout_latency", 32'(cnt), 101);
        chk("timeout_error", 32'(error), 1);
        chk("timeout_rdata_kept", 32'(rdata), 32'(exp_rdata));
        stuck_at = -1;
        repeat (10) @(negedge clk);
`endif

        // Asynchronous reset while waiting on the register-index phase of a read.
        base = trigs.size();
        stuck_at = base + 1;
        txn_base = base;
        nak_mask = '0;
        @(negedge clk);
        rw = 1'b1; dev_address = 7'h50; reg_address = 8'h02; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (trigs.size() == base + 2 && ctl_busy === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        chk("midreset_reached_reg_phase", 32'(got), 1);
        chk("midreset_busy_before", 32'(busy), 1);
        chk("midreset_reg_byte_before", 32'(ctl_write_data), 32'h02);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        stuck_at = -1;
        exp_rdata = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        do_txn(1'b0, 7'h50, 8'h10, 8'hA5, 5'b00000, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
